// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte
// producers. A grant issues a one-cycle start pulse with the latched byte,
// then holds off further grants for FRAME_CLKS clocks so the transmitter
// is never started while it is still shifting out a frame.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int IDW        = 2,
  parameter int FRAME_CLKS = 9556
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] data_in,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 uart_start,
  output logic [7:0]           uart_data,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy
);

  localparam int                 CNT_W    = $clog2(FRAME_CLKS);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(FRAME_CLKS - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT  = NUM_REQ'(1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic                 win_found;
  logic [IDW-1:0]       win_idx;
  logic [8*NUM_REQ-1:0] data_shift;
  logic [7:0]           win_byte;

  // Returns {found, index} of the first set request searching upward from
  // the requester after the last grant, wrapping at NUM_REQ so indices
  // beyond the last requester are never produced.
  function automatic logic [IDW:0] pick_winner(
    input logic [NUM_REQ-1:0] r,
    input logic [IDW-1:0]     last
  );
    logic [IDW:0] res;
    int           cand;
    res = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last) + k) % NUM_REQ;
      if (!res[IDW] && r[cand]) begin
        res = {1'b1, IDW'(cand)};
      end
    end
    return res;
  endfunction

  // Arbitration result and the winner's byte, consumed only in IDLE.
  always_comb begin
    {win_found, win_idx} = pick_winner(req, grant_id);
    data_shift           = data_in >> {win_idx, 3'b000};
    win_byte             = data_shift[7:0];
  end

  // Grant FSM: arbitrate in IDLE, then count out one frame time in WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ack        <= '0;
      uart_start <= 1'b0;
      uart_data  <= 8'h00;
      grant_id   <= IDW'(NUM_REQ - 1);
      busy       <= 1'b0;
    end else begin
      ack        <= '0;
      uart_start <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            uart_data  <= win_byte;
            grant_id   <= win_idx;
            ack        <= ONE_HOT << win_idx;
            uart_start <= 1'b1;
            busy       <= 1'b1;
            cnt        <= CNT_LOAD;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a short frame time.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int IDW        = 2;
  localparam int FRAME_CLKS = 20;

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] data_in;
  logic [NUM_REQ-1:0]   ack;
  logic                 uart_start;
  logic [7:0]           uart_data;
  logic [IDW-1:0]       grant_id;
  logic                 busy;

  uart_tx_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .IDW       (IDW),
    .FRAME_CLKS(FRAME_CLKS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data_in   (data_in),
    .ack       (ack),
    .uart_start(uart_start),
    .uart_data (uart_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [1:0]  id;
    logic [7:0]  exp_byte;
  } vec_t;

  typedef struct {
    logic [1:0] id;
    logic [7:0] b;
  } exp_t;

  vec_t vecs[8];
  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  logic prev_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for a start pulse; n = negedges elapsed.
  task automatic wait_start(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!uart_start && n < 200);
    if (!uart_start) check({name, "_timeout"}, uart_start, 1);
  endtask

  // Counts negedges with busy high starting from the current one.
  task automatic busy_len(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Scoreboard monitor: every start pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (uart_start) begin
        exp_t e;
        check("start_after_idle_cycle", prev_busy, 0);
        check("start_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("ack_onehot", ack, 4'b0001 << e.id);
          check("uart_data", uart_data, e.b);
          check("grant_id", grant_id, e.id);
          check("busy_at_start", busy, 1);
        end
      end else begin
        check("ack_without_start", ack, 0);
      end
    end
    prev_busy = busy;
  end

  initial begin
    int n;
    int starts;

    vecs[0] = '{4'b0001, 32'h000000A5, 2'd0, 8'hA5};
    vecs[1] = '{4'b1111, 32'h13121110, 2'd1, 8'h11};
    vecs[2] = '{4'b0011, 32'h13121110, 2'd0, 8'h10};
    vecs[3] = '{4'b0010, 32'h13121110, 2'd1, 8'h11};
    vecs[4] = '{4'b1000, 32'h13121110, 2'd3, 8'h13};
    vecs[5] = '{4'b0101, 32'h13121110, 2'd0, 8'h10};
    vecs[6] = '{4'b0101, 32'h13121110, 2'd2, 8'h12};
    vecs[7] = '{4'b0110, 32'h13121110, 2'd1, 8'h11};

    rst     = 1'b0;
    req     = '0;
    data_in = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_start", uart_start, 0);
    check("rst_data", uart_data, 8'h00);
    check("rst_grant_id", grant_id, NUM_REQ - 1);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_no_req_busy", busy, 0);

    // Single grants from IDLE, round-robin pointer carried between vectors.
    for (int i = 0; i < 8; i++) begin
      data_in = vecs[i].data;
      req     = vecs[i].req;
      q.push_back('{vecs[i].id, vecs[i].exp_byte});
      wait_start($sformatf("vec%0d", i), n);
      check($sformatf("vec%0d_latency", i), n, 1);
      req = '0;
      busy_len(n);
      check($sformatf("vec%0d_busy_len", i), n, FRAME_CLKS);
    end

    // Continuous request from requester 2: pulses FRAME_CLKS+1 apart.
    data_in = 32'h003C0000;
    req     = 4'b0100;
    repeat (3) q.push_back('{2'd2, 8'h3C});
    wait_start("hold2_first", n);
    check("hold2_latency", n, 1);
    for (int g = 0; g < 2; g++) begin
      wait_start("hold2", n);
      check($sformatf("hold2_spacing%0d", g), n, FRAME_CLKS + 1);
    end
    req = '0;
    busy_len(n);

    // Requester 3 raises and drops req inside WAIT: must never be served.
    data_in = 32'h770000A5;
    req     = 4'b0001;
    q.push_back('{2'd0, 8'hA5});
    wait_start("drop3_grant", n);
    check("drop3_grant_latency", n, 1);
    req = 4'b0000;
    repeat (3) @(negedge clk);
    req = 4'b1000;
    repeat (5) @(negedge clk);
    req = 4'b0000;
    busy_len(n);
    starts = 0;
    repeat (30) begin
      @(negedge clk);
      if (uart_start) starts++;
    end
    check("drop3_no_start", starts, 0);

    // Asynchronous reset five clocks into WAIT.
    data_in = 32'h13121110;
    req     = 4'b0010;
    q.push_back('{2'd1, 8'h11});
    wait_start("mid_rst_grant", n);
    req = '0;
    repeat (5) @(negedge clk);
    check("mid_rst_busy_before", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_ack", ack, 0);
    check("mid_rst_start", uart_start, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_grant_id", grant_id, NUM_REQ - 1);
    repeat (2) @(negedge clk);
    rst     = 1'b1;
    data_in = 32'h000000A5;
    req     = 4'b0001;
    q.push_back('{2'd0, 8'hA5});
    wait_start("post_rst", n);
    check("post_rst_latency", n, 1);
    req = '0;
    busy_len(n);
    check("post_rst_busy_len", n, FRAME_CLKS);

    // Fresh reset, then all four requesters held: order 0,1,2,3,0.
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst     = 1'b1;
    data_in = 32'h13121110;
    req     = 4'b1111;
    q.push_back('{2'd0, 8'h10});
    q.push_back('{2'd1, 8'h11});
    q.push_back('{2'd2, 8'h12});
    q.push_back('{2'd3, 8'h13});
    q.push_back('{2'd0, 8'h10});
    wait_start("all_first", n);
    check("all_latency", n, 1);
    for (int g = 0; g < 4; g++) begin
      wait_start("all", n);
      check($sformatf("all_spacing%0d", g), n, FRAME_CLKS + 1);
    end
    req = '0;
    busy_len(n);
    repeat (5) @(negedge clk);
    check("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
